// File: rtl/ex_operand_sel_if.sv
// EX operand-resolver bus: forwarding sources, hit flags, stall controls
// and the resolved operands returned to the EX stage.
interface ex_operand_sel_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] rd_data_ma;
  logic [XLEN-1:0] rd_data_wb;
  logic            hit_rs1_idex_ex;
  logic            hit_rs1_idma_ex;
  logic            hit_rs1_idwb_ex;
  logic            nohit_rs1_ex;
  logic            hit_rs2_idex_ex;
  logic            hit_rs2_idma_ex;
  logic            hit_rs2_idwb_ex;
  logic            nohit_rs2_ex;
  logic            stall_ld_ex;
  logic            stall;
  logic            rst_pipe;
  logic [XLEN-1:0] rs1_val_ex;
  logic [XLEN-1:0] rs2_val_ex;
  logic            opr_held;

  modport master (
    output rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb,
           hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
           hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
           stall_ld_ex, stall, rst_pipe,
    input  rs1_val_ex, rs2_val_ex, opr_held
  );

  modport slave (
    input  rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb,
           hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
           hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
           stall_ld_ex, stall, rst_pipe,
    output rs1_val_ex, rs2_val_ex, opr_held
  );
endinterface

// File: rtl/ex_operand_sel.sv
// EX-stage operand resolver: picks forwarded or register-file operands and
// freezes them in hold registers for the duration of a pipeline stall.
module ex_operand_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_operand_sel_if.slave   bus
);

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            capture_c;
  logic [XLEN-1:0] wb_dly_q;
  logic [XLEN-1:0] hold1_q;
  logic [XLEN-1:0] hold2_q;
  logic [XLEN-1:0] sel1_c;
  logic [XLEN-1:0] sel2_c;

  // Forwarding priority: youngest producer wins.
  function automatic logic [XLEN-1:0] pick(
    input logic            idex,
    input logic            idma,
    input logic            idwb,
    input logic [XLEN-1:0] ma,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] dly,
    input logic [XLEN-1:0] rf
  );
    if (idex)      return ma;
    else if (idma) return wb;
    else if (idwb) return dly;
    else           return rf;
  endfunction

  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    if (!bus.stall_ld_ex) begin
      sel1_c = pick(bus.hit_rs1_idex_ex, bus.hit_rs1_idma_ex, bus.hit_rs1_idwb_ex,
                    bus.rd_data_ma, bus.rd_data_wb, wb_dly_q, bus.rs1_data_ex);
      sel2_c = pick(bus.hit_rs2_idex_ex, bus.hit_rs2_idma_ex, bus.hit_rs2_idwb_ex,
                    bus.rd_data_ma, bus.rd_data_wb, wb_dly_q, bus.rs2_data_ex);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LIVE;
    else        state_q <= state_d;
  end

  // Hold sequencing; a flush always returns to live selection.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    if (bus.rst_pipe) begin
      state_d = ST_LIVE;
    end else begin
      case (state_q)
        ST_LIVE: begin
          if (bus.stall) begin
            state_d   = ST_HELD;
            capture_c = 1'b1;
          end
        end
        ST_HELD: begin
          if (!bus.stall) state_d = ST_LIVE;
        end
        default: state_d = ST_LIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold1_q <= '0;
      hold2_q <= '0;
    end else if (bus.rst_pipe) begin
      hold1_q <= '0;
      hold2_q <= '0;
    end else if (capture_c) begin
      hold1_q <= sel1_c;
      hold2_q <= sel2_c;
    end
  end

  // Retired-result delay line; frozen with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            wb_dly_q <= '0;
    else if (bus.rst_pipe) wb_dly_q <= '0;
    else if (!bus.stall)   wb_dly_q <= bus.rd_data_wb;
  end

  assign bus.opr_held   = (state_q == ST_HELD);
  assign bus.rs1_val_ex = (state_q == ST_HELD) ? hold1_q : sel1_c;
  assign bus.rs2_val_ex = (state_q == ST_HELD) ? hold2_q : sel2_c;

  nohit1_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    bus.nohit_rs1_ex == ~(bus.hit_rs1_idex_ex | bus.hit_rs1_idma_ex | bus.hit_rs1_idwb_ex));
  nohit2_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    bus.nohit_rs2_ex == ~(bus.hit_rs2_idex_ex | bus.hit_rs2_idma_ex | bus.hit_rs2_idwb_ex));

endmodule

// File: tb/tb_ex_operand_sel.sv
// Self-checking bench for ex_operand_sel: vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_ex_operand_sel;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ex_operand_sel_if #(.XLEN(32)) bus ();

  ex_operand_sel #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.nohit_rs1_ex = ~(bus.hit_rs1_idex_ex | bus.hit_rs1_idma_ex | bus.hit_rs1_idwb_ex);
  assign bus.nohit_rs2_ex = ~(bus.hit_rs2_idex_ex | bus.hit_rs2_idma_ex | bus.hit_rs2_idwb_ex);

  // hit vectors: bit0 = idex (MA), bit1 = idma (WB), bit2 = idwb (retired)
  typedef struct {
    logic [31:0] rs1, rs2, ma, wb;
    logic [2:0]  h1, h2;
    logic        sld;
    logic [31:0] exp1, exp2;
  } vec_t;

  // Behavioural model state
  logic [31:0] m_prev_wb;
  logic        m_held;
  logic [31:0] m_h [2];

  function automatic logic [31:0] live_val(int op);
    logic [31:0] src [3];
    logic [2:0]  h;
    src[0] = bus.rd_data_ma;
    src[1] = bus.rd_data_wb;
    src[2] = m_prev_wb;
    if (bus.stall_ld_ex) return 32'd0;
    h = (op == 0) ? {bus.hit_rs1_idwb_ex, bus.hit_rs1_idma_ex, bus.hit_rs1_idex_ex}
                  : {bus.hit_rs2_idwb_ex, bus.hit_rs2_idma_ex, bus.hit_rs2_idex_ex};
    for (int k = 0; k < 3; k++) if (h[k]) return src[k];
    return (op == 0) ? bus.rs1_data_ex : bus.rs2_data_ex;
  endfunction

  function automatic logic [31:0] model_val(int op);
    return m_held ? m_h[op] : live_val(op);
  endfunction

  task automatic model_reset();
    m_prev_wb = 32'd0;
    m_held    = 1'b0;
    m_h[0]    = 32'd0;
    m_h[1]    = 32'd0;
  endtask

  // Advance model with the inputs present at the coming edge, then clock.
  task automatic tick();
    logic [31:0] l0, l1;
    l0 = live_val(0);
    l1 = live_val(1);
    if (bus.rst_pipe) begin
      model_reset();
    end else begin
      if (bus.stall && !m_held) begin
        m_h[0] = l0;
        m_h[1] = l1;
        m_held = 1'b1;
      end else if (!bus.stall) begin
        m_held = 1'b0;
      end
      if (!bus.stall) m_prev_wb = bus.rd_data_wb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] rs1, rs2, ma, wb,
                       input logic [2:0] h1, h2,
                       input logic sld, st, rp);
    bus.rs1_data_ex     = rs1;
    bus.rs2_data_ex     = rs2;
    bus.rd_data_ma      = ma;
    bus.rd_data_wb      = wb;
    bus.hit_rs1_idex_ex = h1[0];
    bus.hit_rs1_idma_ex = h1[1];
    bus.hit_rs1_idwb_ex = h1[2];
    bus.hit_rs2_idex_ex = h2[0];
    bus.hit_rs2_idma_ex = h2[1];
    bus.hit_rs2_idwb_ex = h2[2];
    bus.stall_ld_ex     = sld;
    bus.stall           = st;
    bus.rst_pipe        = rp;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t tbl [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("reset_rs1", bus.rs1_val_ex, 32'd0);
    check("reset_rs2", bus.rs2_val_ex, 32'd0);
    check("reset_held", 32'(bus.opr_held), 32'd0);
    tick();

    tbl[0] = '{32'h11, 32'h12, 32'h22, 32'h33, 3'b011, 3'b000, 1'b0, 32'h22, 32'h12};
    tbl[1] = '{32'h11, 32'h12, 32'h22, 32'h33, 3'b010, 3'b000, 1'b0, 32'h33, 32'h12};
    tbl[2] = '{32'h11, 32'h12, 32'h22, 32'h33, 3'b000, 3'b001, 1'b0, 32'h11, 32'h22};
    tbl[3] = '{32'h11, 32'h12, 32'h22, 32'h33, 3'b111, 3'b110, 1'b0, 32'h22, 32'h33};
    tbl[4] = '{32'hAA, 32'hBB, 32'h01, 32'h02, 3'b100, 3'b000, 1'b0, 32'h33, 32'hBB};
    tbl[5] = '{32'hAA, 32'hBB, 32'h77, 32'h02, 3'b001, 3'b111, 1'b1, 32'h00, 32'h00};
    tbl[6] = '{32'h05, 32'h06, 32'h01, 32'h09, 3'b000, 3'b000, 1'b0, 32'h05, 32'h06};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].ma, tbl[i].wb, tbl[i].h1, tbl[i].h2,
            tbl[i].sld, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_rs1", i), bus.rs1_val_ex, tbl[i].exp1);
      check($sformatf("vec%0d_rs2", i), bus.rs2_val_ex, tbl[i].exp2);
      check($sformatf("vec%0d_held", i), 32'(bus.opr_held), 32'd0);
      tick();
    end

    // Retired path: value from the previous unstalled cycle
    drive(1, 2, 3, 32'hABCD0001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1, 2, 3, 32'h5, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("retired_rs2", bus.rs2_val_ex, 32'hABCD0001);
    tick();

    // Stall hold across changing WB result
    drive(1, 2, 3, 32'h40, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("prestall_rs1", bus.rs1_val_ex, 32'h40);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 2, 3, (c == 1) ? 32'h40 : 32'h99, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("stall%0d_rs1", c), bus.rs1_val_ex, 32'h40);
      check($sformatf("stall%0d_held", c), 32'(bus.opr_held), (c == 1) ? 32'd0 : 32'd1);
      tick();
    end
    drive(1, 2, 3, 32'h99, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("release_rs1", bus.rs1_val_ex, 32'h99);
    check("release_held", 32'(bus.opr_held), 32'd0);
    tick();

    // Release and reassert on consecutive cycles: recapture new selection
    drive(1, 2, 32'h61, 32'h99, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1, 2, 32'h62, 32'h99, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1, 2, 32'h63, 32'h99, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1, 2, 32'h64, 32'h99, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("restall_rs1", bus.rs1_val_ex, 32'h63);
    check("restall_held", 32'(bus.opr_held), 32'd1);
    tick();

    // Flush while holding: wb_dly and hold cleared
    drive(1, 2, 3, 32'h99, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1, 2, 3, 32'h99, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_held", 32'(bus.opr_held), 32'd0);
    check("flush_idwb_rs1", bus.rs1_val_ex, 32'd0);
    tick();
    drive(1, 2, 3, 32'h99, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Async reset mid-stall
    drive(1, 2, 3, 32'h7, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("pre_areset_held", 32'(bus.opr_held), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_held", 32'(bus.opr_held), 32'd0);
    drive(32'h123, 32'h456, 3, 32'h7, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("areset_rs1", bus.rs1_val_ex, 32'h123);
    check("areset_rs2", bus.rs2_val_ex, 32'h456);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      drive($urandom, $urandom, $urandom, $urandom,
            3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 19) == 0));
      @(negedge clk);
      check("rand_rs1", bus.rs1_val_ex, model_val(0));
      check("rand_rs2", bus.rs2_val_ex, model_val(1));
      check("rand_held", 32'(bus.opr_held), 32'(m_held));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
